// File: rtl/rx_decoder_pkg.sv
// ============================================================================
// Module      : rx_decoder_pkg
// Description : Shared FSM state encoding, nominal pulse durations and the
//               width-window helper for the pulse-width receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD_H = 3'd1,
    LEAD_L = 3'd2,
    BIT_H  = 3'd3,
    BIT_L  = 3'd4
  } state_t;

  // Nominal durations at 50 MHz, shared with the transmitter
  localparam int CLKS_LEADER_DEF = 100000;
  localparam int CLKS_GAP_DEF    = 25000;
  localparam int CLKS_BIT0_DEF   = 25000;
  localparam int CLKS_BIT1_DEF   = 50000;
  localparam int CLKS_STOP_DEF   = 75000;
  localparam int TOL_DEF         = 4000;
  localparam int CNT_W_DEF       = 17;
  localparam int FILTER_LEN_DEF  = 4;

  function automatic logic in_window(input int w, input int n, input int tol);
    return (w >= n - tol) && (w <= n + tol);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_decoder_if.sv
// ============================================================================
// Module      : rx_decoder_if
// Description : Serial line input and decoded byte/status outputs of rx_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_decoder_if;
  logic       Din;
  logic [7:0] Dout;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (output Din, input Dout, data_valid, frame_err, busy);
  modport slave  (input Din, output Dout, data_valid, frame_err, busy);
endinterface

`default_nettype wire

// File: rtl/rx_line_sync.sv
// ============================================================================
// Module      : rx_line_sync
// Description : 2-flop synchronizer, optional glitch filter (RX_GLITCH_FILTER_EN)
//               and edge detector producing line level, rise and fall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_line_sync #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic line,
  output logic rise,
  output logic fall
);

`ifdef RX_GLITCH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif
  // Edges are masked until the pipeline has been refilled after reset, so a
  // line that is already high at reset never looks like a rise.
  localparam int PRIME = FILTER_ON ? FILTER_LEN + 3 : 3;

  logic             sync1, sync2, lvl, prev;
  logic [PRIME-1:0] prime;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  generate
    if (FILTER_ON) begin : g_filter
      localparam int FCW = $clog2(FILTER_LEN + 1);
      logic [FCW-1:0] fcnt;
      logic           filt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          fcnt <= '0;
          filt <= 1'b0;
        end else if (sync2 == filt) begin
          fcnt <= '0;
        end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
          filt <= sync2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end

      assign lvl = filt;
    end else begin : g_bypass
      assign lvl = sync2;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b0;
      prime <= '0;
    end else begin
      prev  <= lvl;
      prime <= {prime[PRIME-2:0], 1'b1};
    end
  end

  assign line = lvl;
  assign rise = prime[PRIME-1] &  lvl & ~prev;
  assign fall = prime[PRIME-1] & ~lvl &  prev;

endmodule

`default_nettype wire

// File: rtl/rx_decoder.sv
// ============================================================================
// Module      : rx_decoder
// Description : Pulse-width serial frame decoder (leader, 8 bits MSB first,
//               stop). Optional glitch filter: define RX_GLITCH_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_decoder
  import rx_decoder_pkg::*;
#(
  parameter int CLKS_LEADER = CLKS_LEADER_DEF,
  parameter int CLKS_GAP    = CLKS_GAP_DEF,
  parameter int CLKS_BIT0   = CLKS_BIT0_DEF,
  parameter int CLKS_BIT1   = CLKS_BIT1_DEF,
  parameter int CLKS_STOP   = CLKS_STOP_DEF,
  parameter int TOL         = TOL_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic        CLK_50M,
  input  logic        reset,
  rx_decoder_if.slave bus
);

  logic             line, rise, fall, edge_seen;
  logic [CNT_W-1:0] cnt;
  int               w, lim;

  state_t      state, state_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  dout_r, dout_nxt;
  logic        valid_r, valid_nxt;
  logic        err_r, abort;

  rx_line_sync #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync (
    .clk  (CLK_50M),
    .rst  (reset),
    .din  (bus.Din),
    .line (line),
    .rise (rise),
    .fall (fall)
  );

  assign edge_seen = rise | fall;

  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (edge_seen)
      cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
    else if (cnt != {CNT_W{1'b1}})
      cnt <= cnt + 1'b1;
  end

  assign w = int'(cnt);

  // Longest width the current phase may reach before it is a timeout
  always_comb begin
    lim = 0;
    case (state)
      LEAD_H:         lim = CLKS_LEADER + TOL;
      LEAD_L, BIT_L:  lim = CLKS_GAP + TOL;
      BIT_H:          lim = (bit_cnt == 4'd8) ? CLKS_STOP + TOL : CLKS_BIT1 + TOL;
      default:        lim = 0;
    endcase
  end

  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= 8'h00;
      bit_cnt <= 4'd0;
      dout_r  <= 8'h00;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      dout_r  <= dout_nxt;
      valid_r <= valid_nxt;
      err_r   <= abort;
    end
  end

  // Closing edges are checked for direction via the line level, so an edge of
  // the wrong polarity also aborts the frame.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    dout_nxt    = dout_r;
    valid_nxt   = 1'b0;
    abort       = 1'b0;
    if (state != IDLE && w > lim) begin
      abort = 1'b1;
    end else begin
      case (state)
        IDLE: if (rise) state_nxt = LEAD_H;
        LEAD_H: if (edge_seen) begin
          if (!line && in_window(w, CLKS_LEADER, TOL)) state_nxt = LEAD_L;
          else abort = 1'b1;
        end
        LEAD_L, BIT_L: if (edge_seen) begin
          if (line && in_window(w, CLKS_GAP, TOL)) begin
            state_nxt = BIT_H;
            if (state == LEAD_L) bit_cnt_nxt = 4'd0;
          end else begin
            abort = 1'b1;
          end
        end
        BIT_H: if (edge_seen) begin
          if (line) begin
            abort = 1'b1;
          end else if (bit_cnt == 4'd8) begin
            if (in_window(w, CLKS_STOP, TOL)) begin
              dout_nxt  = shift;
              valid_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              abort = 1'b1;
            end
          end else if (in_window(w, CLKS_BIT0, TOL) || in_window(w, CLKS_BIT1, TOL)) begin
            shift_nxt   = {shift[6:0], in_window(w, CLKS_BIT1, TOL)};
            bit_cnt_nxt = bit_cnt + 4'd1;
            state_nxt   = BIT_L;
          end else begin
            abort = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (abort) state_nxt = IDLE;
  end

  assign bus.Dout       = dout_r;
  assign bus.data_valid = valid_r;
  assign bus.frame_err  = err_r;
  assign bus.busy       = (state != IDLE);

endmodule

`default_nettype wire
